multi_timer: RTL
================

Name: multi_timer

Overview:
- Memory-mapped timer peripheral with a shared free-running cycle counter and NUM_TIMERS independent compare channels.
- Each channel runs in one-shot or periodic (auto-reload) mode and has its own pending bit and interrupt-enable bit.
- Raises one combined TimerInterrupt to the processor's interrupt logic.
- Sits on the data-memory bus beside the data memory; decode is flagged by TimerAddress so the datapath can steer load data.

Parameters:
- NUM_TIMERS, 4, number of compare channels (1..8).
- COUNT_WIDTH, 32, width of the cycle counter and compare/period registers (8..32).
- BASE_ADDR, 32'hffff0000, word-aligned base of the register window.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- data  input  32  store data from the datapath.
- address  input  32  memory address from the datapath.
- MemRead  input  1  load strobe.
- MemWrite  input  1  store strobe.
- rdata  output  32  load data; 0 when no readable register is decoded.
- TimerAddress  output  1  address hits any register in the window (combinational).
- TimerInterrupt  output  1  OR over channels of (pending[i] & ie[i]).
- pending  output  NUM_TIMERS  raw pending bits, for debug/trace.

Behaviour:
- Register map (byte offsets from BASE_ADDR; full 32-bit compare, unaligned or unmapped = no hit):
  - 0x00 CYCLE, RW.
  - 0x04 STATUS, R = pending, W = write-1-to-clear.
  - 0x08 CTRL, RW: bits[7:0] = enable, bits[15:8] = periodic, bits[23:16] = ie.
  - 0x10+8*i COMPARE_i, RW.
  - 0x14+8*i PERIOD_i, RW.
  - CTRL bits for channels ≥ NUM_TIMERS read 0 and ignore writes.
- Reset (reset==0, async): cycle=0; compare_i=all ones; period_i=0; enable, periodic, ie, pending=0. TimerInterrupt=0 and rdata=0 immediately.
- Cycle counter: increments by 1 every clock, wrapping from 2^COUNT_WIDTH-1 to 0. A CYCLE write loads data[COUNT_WIDTH-1:0] instead of incrementing that edge.
- Width: narrow registers take the low data bits on write and are zero-extended on read.
- Fire condition, channel i: enable[i] && cycle==compare_i, evaluated on current register values. pending[i] is set at the same edge, so pending is visible 1 cycle after the match cycle.
- Periodic mode: on fire, compare_i <= compare_i + period_i (mod 2^COUNT_WIDTH) at the same edge. period_i==0 with periodic=1 behaves as one-shot: compare is unchanged and there is no refire until the counter wraps.
- One-shot mode: compare unchanged; fires again only when the counter wraps back to compare_i.
- Simultaneous events:
  - Fire and STATUS W1C on the same bit: set wins, pending stays 1.
  - Fire and COMPARE_i write: the write wins, pending is still set.
  - CYCLE write and a match in the same cycle: the match is still evaluated on the pre-write value.
- Clearing enable[i] leaves pending[i] untouched. Clearing ie[i] masks the interrupt but keeps pending.
- Reads are combinational: rdata reflects current register values when MemRead and the address hits. CYCLE returns the pre-increment value.
- MemRead and MemWrite both high at the same address: the write is performed and rdata shows the old value.
- Mid-operation reset: every register returns to its reset value asynchronously; no pending bit survives.

Decomposition:
- Shared package multi_timer_pkg holds the register offsets (OFF_CYCLE, OFF_STATUS, OFF_CTRL, OFF_CH_BASE, CH_STRIDE) and the CTRL field positions.
- Sub-module timer_channel (×NUM_TIMERS via generate) owns compare, period and pending. Its inputs are cycle, enable, periodic, ack, the compare/period write enables and data; its outputs are compare, period and pending.
- Top level holds the counter, CTRL register, address decode and read mux.

Test Plan:
- Reset released; write COMPARE_0=10, CTRL=0x010001 at cycle 3 → pending[0] and TimerInterrupt rise the edge after cycle==10; STATUS reads 0x1; W1C 0x1 clears both next edge.
- Periodic: COMPARE_1=20, PERIOD_1=5, enable+periodic+ie for ch1 → fires at counts 20, 25, 30; COMPARE_1 reads 35 after the third fire.
- Ack collision: W1C bit 2 issued in the exact match cycle of ch2 → pending[2] remains 1. A W1C one cycle later clears it.
- Wrap: COUNT_WIDTH=8, CYCLE written 250, COMPARE_0=2, one-shot → counter goes 255→0; fires at 2; no second fire until 2 recurs 256 cycles later.
- Mask/unmapped: ie[0]=0 with a match → pending[0]=1 and TimerInterrupt=0. A read at BASE+0x0C or BASE+0x02 gives TimerAddress=0 and rdata=0.
- Async reset asserted mid-count with pending=0xF → all outputs 0 before the next clock edge; CYCLE reads 0 after release.

Source files
------------

// File: rtl/multi_timer_pkg.sv
// Register map offsets and CTRL field layout shared by the multi_timer top and its channels.
package multi_timer_pkg;
  localparam logic [31:0] OFF_CYCLE   = 32'h00;
  localparam logic [31:0] OFF_STATUS  = 32'h04;
  localparam logic [31:0] OFF_CTRL    = 32'h08;
  localparam logic [31:0] OFF_CH_BASE = 32'h10;
  localparam logic [31:0] CH_STRIDE   = 32'h08;

  localparam int CTRL_EN_LSB  = 0;
  localparam int CTRL_PER_LSB = 8;
  localparam int CTRL_IE_LSB  = 16;
endpackage

// File: rtl/timer_channel.sv
// One compare channel: compare/period registers and a sticky pending bit set on match.
// Pending rises the edge after the match cycle; a same-edge ack loses to a fire.
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [COUNT_WIDTH-1:0] cycle_i,
  input  logic                   enable_i,
  input  logic                   periodic_i,
  input  logic                   ack_i,
  input  logic                   cmp_we_i,
  input  logic                   per_we_i,
  input  logic [COUNT_WIDTH-1:0] wdata_i,
  output logic [COUNT_WIDTH-1:0] compare_o,
  output logic [COUNT_WIDTH-1:0] period_o,
  output logic                   pending_o
);
  logic [COUNT_WIDTH-1:0] compare_q, compare_d;
  logic [COUNT_WIDTH-1:0] period_q, period_d;
  logic                   pending_q, pending_d;
  logic                   fire;

  always_comb begin
    fire      = enable_i && (cycle_i == compare_q);
    compare_d = compare_q;
    // A bus write to compare overrides the periodic reload in the same cycle.
    if (cmp_we_i) begin
      compare_d = wdata_i;
    end else if (fire && periodic_i) begin
      compare_d = compare_q + period_q;
    end
    period_d  = per_we_i ? wdata_i : period_q;
    pending_d = fire | (pending_q & ~ack_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      compare_q <= '1;
      period_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      compare_q <= compare_d;
      period_q  <= period_d;
      pending_q <= pending_d;
    end
  end

  assign compare_o = compare_q;
  assign period_o  = period_q;
  assign pending_o = pending_q;
endmodule

// File: rtl/multi_timer.sv
// Memory-mapped timer: free-running counter, CTRL register, address decode and read mux.
// Reads are combinational (zero latency); writes take effect at the next rising edge.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int          NUM_TIMERS  = 4,
  parameter int          COUNT_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR   = 32'hffff0000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           data,
  input  logic [31:0]           address,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  output logic [31:0]           rdata,
  output logic                  TimerAddress,
  output logic                  TimerInterrupt,
  output logic [NUM_TIMERS-1:0] pending
);
  localparam logic [31:0] CH_END = OFF_CH_BASE + CH_STRIDE * 32'(NUM_TIMERS);

  logic [COUNT_WIDTH-1:0] cycle_q, cycle_d;
  logic [NUM_TIMERS-1:0]  enable_q, enable_d, periodic_q, periodic_d, ie_q, ie_d;
  logic [NUM_TIMERS-1:0]  cmp_we, per_we, ack;
  logic [COUNT_WIDTH-1:0] compare_w [NUM_TIMERS];
  logic [COUNT_WIDTH-1:0] period_w  [NUM_TIMERS];
  logic [31:0]            off, ctrl_rd;
  logic [2:0]             ch_idx;
  logic                   hit_cycle, hit_status, hit_ctrl, hit_ch;

  // Addresses below the base wrap to huge offsets and so miss the window.
  always_comb begin
    off          = address - BASE_ADDR;
    hit_cycle    = (off == OFF_CYCLE);
    hit_status   = (off == OFF_STATUS);
    hit_ctrl     = (off == OFF_CTRL);
    hit_ch       = (off >= OFF_CH_BASE) && (off < CH_END) && (off[1:0] == 2'b00);
    ch_idx       = 3'((off - OFF_CH_BASE) >> 3);
    TimerAddress = hit_cycle | hit_status | hit_ctrl | hit_ch;
  end

  always_comb begin
    cycle_d    = cycle_q + COUNT_WIDTH'(1);
    enable_d   = enable_q;
    periodic_d = periodic_q;
    ie_d       = ie_q;
    ack        = '0;
    cmp_we     = '0;
    per_we     = '0;
    if (MemWrite) begin
      if (hit_cycle) cycle_d = data[COUNT_WIDTH-1:0];
      if (hit_status) ack = data[NUM_TIMERS-1:0];
      if (hit_ctrl) begin
        enable_d   = data[CTRL_EN_LSB  +: NUM_TIMERS];
        periodic_d = data[CTRL_PER_LSB +: NUM_TIMERS];
        ie_d       = data[CTRL_IE_LSB  +: NUM_TIMERS];
      end
      for (int i = 0; i < NUM_TIMERS; i++) begin
        if (hit_ch && ch_idx == 3'(i)) begin
          cmp_we[i] = ~off[2];
          per_we[i] = off[2];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_q    <= '0;
      enable_q   <= '0;
      periodic_q <= '0;
      ie_q       <= '0;
    end else begin
      cycle_q    <= cycle_d;
      enable_q   <= enable_d;
      periodic_q <= periodic_d;
      ie_q       <= ie_d;
    end
  end

  for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_ch
    timer_channel #(.COUNT_WIDTH(COUNT_WIDTH)) u_ch (
      .clk_i      (clock),
      .rst_ni     (reset),
      .cycle_i    (cycle_q),
      .enable_i   (enable_q[g]),
      .periodic_i (periodic_q[g]),
      .ack_i      (ack[g]),
      .cmp_we_i   (cmp_we[g]),
      .per_we_i   (per_we[g]),
      .wdata_i    (data[COUNT_WIDTH-1:0]),
      .compare_o  (compare_w[g]),
      .period_o   (period_w[g]),
      .pending_o  (pending[g])
    );
  end

  always_comb begin
    ctrl_rd                               = '0;
    ctrl_rd[CTRL_EN_LSB  +: NUM_TIMERS]   = enable_q;
    ctrl_rd[CTRL_PER_LSB +: NUM_TIMERS]   = periodic_q;
    ctrl_rd[CTRL_IE_LSB  +: NUM_TIMERS]   = ie_q;
    rdata = '0;
    if (MemRead) begin
      if (hit_cycle)  rdata = 32'(cycle_q);
      if (hit_status) rdata = 32'(pending);
      if (hit_ctrl)   rdata = ctrl_rd;
      for (int i = 0; i < NUM_TIMERS; i++) begin
        if (hit_ch && ch_idx == 3'(i)) rdata = off[2] ? 32'(period_w[i]) : 32'(compare_w[i]);
      end
    end
  end

  assign TimerInterrupt = |(pending & ie_q);
endmodule
